// File: rtl/dds_pkg.sv
// Shared DDS definitions: default geometry, wave select codes and the
// voice scheduler state encoding.
// No ports. Optional feature macro used by the scheduler: VOICE_GATE_EN.
package dds_pkg;

  localparam int NUM_VOICES_DEF = 8;
  localparam int PHASE_W_DEF    = 32;
  localparam int ADDR_W_DEF     = 12;
  localparam int SAMPLE_W_DEF   = 24;

  localparam logic [2:0] WAVE_SINE    = 3'd0;
  localparam logic [2:0] WAVE_POS_SAW = 3'd1;
  localparam logic [2:0] WAVE_NEG_SAW = 3'd2;
  localparam logic [2:0] WAVE_TRI     = 3'd3;
  localparam logic [2:0] WAVE_SQ      = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Bundle between the voice scheduler and its neighbours: config writes
// from the SPI decoder, the shared ROM/wave_mux port and the mixed output.
// master: environment side (drives cfg_* and rom_data).
// slave : scheduler side (drives rom_addr, rom_wave_sel, mix_*, busy, overrun).
// cfg_gate exists only when VOICE_GATE_EN is defined.
interface voice_scheduler_if
  import dds_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF
);
  localparam int VOICE_W = $clog2(NUM_VOICES);

  logic                cfg_we;
  logic [VOICE_W-1:0]  cfg_voice;
  logic [PHASE_W-1:0]  cfg_freq;
  logic [2:0]          cfg_wave;
`ifdef VOICE_GATE_EN
  logic                cfg_gate;
`endif
  logic [ADDR_W-1:0]   rom_addr;
  logic [2:0]          rom_wave_sel;
  logic [SAMPLE_W-1:0] rom_data;
  logic [SAMPLE_W-1:0] mix_out;
  logic                mix_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output cfg_we, cfg_voice, cfg_freq, cfg_wave,
`ifdef VOICE_GATE_EN
    output cfg_gate,
`endif
    output rom_data,
    input  rom_addr, rom_wave_sel, mix_out, mix_valid, busy, overrun
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_freq, cfg_wave,
`ifdef VOICE_GATE_EN
    input  cfg_gate,
`endif
    input  rom_data,
    output rom_addr, rom_wave_sel, mix_out, mix_valid, busy, overrun
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Audio sample tick generator: counter runs 0..SAMPLE_DIV-1 and wraps; tick
// is high for the single cycle in which the counter holds SAMPLE_DIV-1.
// Ports: clk, rst (async active-high), tick (registered 1-cycle pulse).
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 500
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             tick_r;

  // Next counter value with wrap at SAMPLE_DIV-1.
  always_comb begin
    if (cnt_r == LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and tick; tick is precomputed so it is high exactly while cnt_r == LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: per sample tick, advances NUM_VOICES phase accumulators,
// issues one shared-ROM lookup per voice, collects the returned samples after
// ROM_LATENCY edges and publishes their average on mix_out.
// Ports: clk, rst (async active-high), bus (voice_scheduler_if.slave).
// Optional feature macro: VOICE_GATE_EN (per-voice gate, gated voices frozen
// and contribute 0, frame timing unchanged).
module voice_scheduler
  import dds_pkg::*;
#(
  parameter int NUM_VOICES  = NUM_VOICES_DEF,
  parameter int PHASE_W     = PHASE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int ROM_LATENCY = 2,
  parameter int SAMPLE_DIV  = 500
) (
  input  logic             clk,
  input  logic             rst,
  voice_scheduler_if.slave bus
);
  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int SUM_W   = SAMPLE_W + VOICE_W;
  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

  logic tick_s;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  logic [NUM_VOICES-1:0][PHASE_W-1:0] shd_freq_r, act_freq_r, acc_r;
  logic [NUM_VOICES-1:0][2:0]         shd_wave_r, act_wave_r;
`ifdef VOICE_GATE_EN
  logic [NUM_VOICES-1:0]              shd_gate_r, act_gate_r;
  logic [ROM_LATENCY-1:0]             pipe_gate_r;
`endif
  sched_state_t           state_r;
  logic [VOICE_W-1:0]     idx_r;
  logic [ROM_LATENCY-1:0] pipe_r;
  logic [SUM_W-1:0]       sum_r;
  logic [ADDR_W-1:0]      rom_addr_r;
  logic [2:0]             rom_wave_sel_r;
  logic [SAMPLE_W-1:0]    mix_out_r;
  logic                   mix_valid_r, busy_r, overrun_r;

  logic [ROM_LATENCY-1:0] pipe_shift_s;
  logic                   capture_s;
  logic [SUM_W-1:0]       sum_add_s;

  // Shadow config: writes always land here, even on a tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_freq_r <= '0;
      shd_wave_r <= '0;
`ifdef VOICE_GATE_EN
      shd_gate_r <= '0;
`endif
    end else if (bus.cfg_we) begin
      shd_freq_r[bus.cfg_voice] <= bus.cfg_freq;
      shd_wave_r[bus.cfg_voice] <= bus.cfg_wave;
`ifdef VOICE_GATE_EN
      shd_gate_r[bus.cfg_voice] <= bus.cfg_gate;
`endif
    end
  end

  // Tag pipe advance and sample accumulation; bit ROM_LATENCY-1 is the entry
  // whose rom_data is valid at the coming edge.
  always_comb begin
    pipe_shift_s = pipe_r << 1;
`ifdef VOICE_GATE_EN
    capture_s = pipe_r[ROM_LATENCY-1] & pipe_gate_r[ROM_LATENCY-1];
`else
    capture_s = pipe_r[ROM_LATENCY-1];
`endif
    if (capture_s) begin
      sum_add_s = sum_r + SUM_W'(bus.rom_data);
    end else begin
      sum_add_s = sum_r;
    end
  end

  // Frame FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      idx_r          <= '0;
      act_freq_r     <= '0;
      act_wave_r     <= '0;
      acc_r          <= '0;
      pipe_r         <= '0;
      sum_r          <= '0;
      rom_addr_r     <= '0;
      rom_wave_sel_r <= 3'd0;
      mix_out_r      <= '0;
      mix_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      overrun_r      <= 1'b0;
`ifdef VOICE_GATE_EN
      act_gate_r     <= '0;
      pipe_gate_r    <= '0;
`endif
    end else begin
      mix_valid_r <= 1'b0;
      pipe_r      <= pipe_shift_s;
      sum_r       <= sum_add_s;
`ifdef VOICE_GATE_EN
      pipe_gate_r <= pipe_gate_r << 1;
`endif
      // A tick that arrives mid-frame is dropped but remembered.
      if (tick_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            act_freq_r <= shd_freq_r;
            act_wave_r <= shd_wave_r;
`ifdef VOICE_GATE_EN
            act_gate_r <= shd_gate_r;
`endif
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          // Address uses the pre-increment phase.
          rom_addr_r     <= acc_r[idx_r][PHASE_W-1 -: ADDR_W];
          rom_wave_sel_r <= act_wave_r[idx_r];
          pipe_r         <= pipe_shift_s | ROM_LATENCY'(1);
`ifdef VOICE_GATE_EN
          pipe_gate_r <= (pipe_gate_r << 1) | ROM_LATENCY'(act_gate_r[idx_r]);
          if (act_gate_r[idx_r]) begin
            acc_r[idx_r] <= acc_r[idx_r] + act_freq_r[idx_r];
          end
`else
          acc_r[idx_r] <= acc_r[idx_r] + act_freq_r[idx_r];
`endif
          if (idx_r == LAST_VOICE) begin
            state_r <= DRAIN;
          end else begin
            idx_r <= idx_r + VOICE_W'(1);
          end
        end
        DRAIN: begin
          // Leave once the last tagged entry exits at this edge.
          if (pipe_shift_s == '0) begin
            state_r <= OUTPUT;
          end
        end
        OUTPUT: begin
          mix_out_r   <= SAMPLE_W'(sum_r >> VOICE_W);
          mix_valid_r <= 1'b1;
          sum_r       <= '0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.rom_addr     = rom_addr_r;
  assign bus.rom_wave_sel = rom_wave_sel_r;
  assign bus.mix_out      = mix_out_r;
  assign bus.mix_valid    = mix_valid_r;
  assign bus.busy         = busy_r;
  assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: frame table plus scoreboard of
// expected ROM issues and mixed samples, an overrun instance with
// SAMPLE_DIV=8, and a mid-frame reset sequence.
module tb_voice_scheduler;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_scheduler_if bus  ();
  voice_scheduler_if bus2 ();

  voice_scheduler #(.SAMPLE_DIV(500)) dut  (.clk(clk), .rst(rst), .bus(bus));
  voice_scheduler #(.SAMPLE_DIV(8))   dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  wave;
  } iss_t;

  typedef struct {
    int          mode;
    logic [23:0] mix;
    logic [11:0] a0;
    logic [11:0] a2;
    logic [11:0] a5;
  } fr_t;

  typedef struct {
    int          frame;
    bit          on_tick;
    logic [2:0]  voice;
    logic [31:0] freq;
    logic [2:0]  wave;
  } wr_t;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int tick_edge = -100;
  int rom_mode = 0;
  bit sb_en = 1'b1;

  logic [31:0] m_acc [8];
  logic [31:0] m_sfreq [8];
  logic [31:0] m_afreq [8];
  logic [2:0]  m_swave [8];
  logic [2:0]  m_awave [8];
  iss_t        iq [$];
  logic [23:0] mq [$];

  logic [11:0] prev_addr = 12'h000;
  int          prev_voice = 0;

  fr_t ft [5];
  wr_t wt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [23:0] rom_f(input int mode, input int voice, input logic [11:0] addr);
    case (mode)
      0:       rom_f = 24'h123456;
      1:       rom_f = 24'(voice) << 20;
      default: rom_f = {addr, 12'h000};
    endcase
  endfunction

  // Be at the falling edge that follows rising edge n.
  task automatic wait_neg(input int n);
    if (edge_cnt > n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sequencing: at edge %0d, wanted %0d", edge_cnt, n);
    end
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic drive_cfg(input bit we, input logic [2:0] v, input logic [31:0] f, input logic [2:0] w);
    bus.cfg_we    = we;
    bus.cfg_voice = v;
    bus.cfg_freq  = f;
    bus.cfg_wave  = w;
`ifdef VOICE_GATE_EN
    bus.cfg_gate  = 1'b1;
`endif
  endtask

  task automatic do_write(input logic [2:0] v, input logic [31:0] f, input logic [2:0] w);
    drive_cfg(1'b1, v, f, w);
    m_sfreq[v] = f;
    m_swave[v] = w;
    @(negedge clk);
    drive_cfg(1'b0, 3'd0, 32'h0, 3'd0);
  endtask

  task automatic open_gates();
`ifdef VOICE_GATE_EN
    for (int v = 0; v < 8; v++) do_write(3'(v), m_sfreq[v], m_swave[v]);
`endif
  endtask

  task automatic model_reset();
    for (int v = 0; v < 8; v++) begin
      m_acc[v] = 32'h0; m_sfreq[v] = 32'h0; m_afreq[v] = 32'h0;
      m_swave[v] = 3'd0; m_awave[v] = 3'd0;
    end
  endtask

  // Tick-edge model: latch shadow, predict every issue and the mix.
  task automatic model_frame(input int mode);
    logic [26:0] sum;
    sum = 27'h0;
    for (int v = 0; v < 8; v++) begin
      m_afreq[v] = m_sfreq[v];
      m_awave[v] = m_swave[v];
    end
    for (int v = 0; v < 8; v++) begin
      iq.push_back('{m_acc[v][31:20], m_awave[v]});
      sum = sum + 27'(rom_f(mode, v, m_acc[v][31:20]));
      m_acc[v] = m_acc[v] + m_afreq[v];
    end
    mq.push_back(24'(sum >> 3));
  endtask

  // ROM model (two-edge latency) and scoreboard consumers, on falling edges.
  task automatic monitor_step();
    int   off;
    iss_t it;
    off = edge_cnt - tick_edge;
    bus.rom_data = rom_f(rom_mode, prev_voice, prev_addr);
    prev_addr  = bus.rom_addr;
    prev_voice = (off >= 1 && off <= 8) ? off - 1 : 0;
    if (sb_en && off >= 1 && off <= 8 && iq.size() > 0) begin
      it = iq.pop_front();
      check("rom_addr", 32'(bus.rom_addr), 32'(it.addr));
      check("rom_wave_sel", 32'(bus.rom_wave_sel), 32'(it.wave));
    end
    if (bus.mix_valid === 1'b1) begin
      if (mq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_mix_valid: got pulse with mix_out 0x%0h, expected none", bus.mix_out);
      end else begin
        check("mix_out_sb", 32'(bus.mix_out), 32'(mq.pop_front()));
        check("mix_latency", 32'(off), 32'd11);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt = rst ? 0 : edge_cnt + 1;
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int te;
    int pulses;
    ft[0] = '{0, 24'h123456, 12'h000, 12'h000, 12'h000};
    ft[1] = '{1, 24'h380000, 12'h000, 12'h000, 12'h000};
    ft[2] = '{2, 24'h100200, 12'h000, 12'h001, 12'h800};
    ft[3] = '{2, 24'h000400, 12'h000, 12'h002, 12'h000};
    ft[4] = '{2, 24'h102600, 12'h010, 12'h003, 12'h800};
    wt[0] = '{1, 1'b0, 3'd2, 32'h0010_0000, WAVE_SINE};
    wt[1] = '{1, 1'b0, 3'd5, 32'h8000_0000, WAVE_SQ};
    wt[2] = '{1, 1'b0, 3'd3, 32'h0000_0000, WAVE_TRI};
    wt[3] = '{2, 1'b1, 3'd0, 32'h0100_0000, WAVE_POS_SAW};

    model_reset();
    rst = 1'b1;
    drive_cfg(1'b0, 3'd0, 32'h0, 3'd0);
    bus.rom_data   = 24'h0;
    bus2.cfg_we    = 1'b0;
    bus2.cfg_voice = 3'd0;
    bus2.cfg_freq  = 32'h0;
    bus2.cfg_wave  = 3'd0;
`ifdef VOICE_GATE_EN
    bus2.cfg_gate  = 1'b0;
`endif
    bus2.rom_data  = 24'h000800;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    check("rst_rom_wave_sel", 32'(bus.rom_wave_sel), 32'h0);
    check("rst_mix_out", 32'(bus.mix_out), 32'h0);
    check("rst_mix_valid", 32'(bus.mix_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b0;

    // SAMPLE_DIV=8 instance: tick at edge 8 starts a frame, tick at 16 overruns.
    wait_neg(15);
    check("ovr_before", 32'(bus2.overrun), 32'h0);
    wait_neg(16);
    check("ovr_set", 32'(bus2.overrun), 32'h1);
    wait_neg(19);
    check("ovr_mix_valid", 32'(bus2.mix_valid), 32'h1);
`ifdef VOICE_GATE_EN
    check("ovr_mix_out", 32'(bus2.mix_out), 32'h0);
`else
    check("ovr_mix_out", 32'(bus2.mix_out), 32'h800);
`endif
    wait_neg(20);
    check("ovr_mix_pulse", 32'(bus2.mix_valid), 32'h0);
    wait_neg(40);
    check("ovr_sticky", 32'(bus2.overrun), 32'h1);
    open_gates();

    for (int f = 0; f < 5; f++) begin
      te = 500 * (f + 1);
      wait_neg(te - 400);
      for (int w = 0; w < 4; w++) begin
        if (wt[w].frame == f && !wt[w].on_tick) do_write(wt[w].voice, wt[w].freq, wt[w].wave);
      end
      wait_neg(te - 1);
      for (int w = 0; w < 4; w++) begin
        if (wt[w].frame == f && wt[w].on_tick) drive_cfg(1'b1, wt[w].voice, wt[w].freq, wt[w].wave);
      end
      wait_neg(te);
      drive_cfg(1'b0, 3'd0, 32'h0, 3'd0);
      tick_edge = te;
      rom_mode  = ft[f].mode;
      model_frame(ft[f].mode);
      for (int w = 0; w < 4; w++) begin
        if (wt[w].frame == f && wt[w].on_tick) begin
          m_sfreq[wt[w].voice] = wt[w].freq;
          m_swave[wt[w].voice] = wt[w].wave;
        end
      end
      check("busy_start", 32'(bus.busy), 32'h1);
      wait_neg(te + 1);
      check("tbl_addr_v0", 32'(bus.rom_addr), 32'(ft[f].a0));
      wait_neg(te + 3);
      check("tbl_addr_v2", 32'(bus.rom_addr), 32'(ft[f].a2));
      wait_neg(te + 6);
      check("tbl_addr_v5", 32'(bus.rom_addr), 32'(ft[f].a5));
      wait_neg(te + 10);
      check("busy_output", 32'(bus.busy), 32'h1);
      check("mix_valid_early", 32'(bus.mix_valid), 32'h0);
      wait_neg(te + 11);
      check("busy_end", 32'(bus.busy), 32'h0);
      check("mix_valid", 32'(bus.mix_valid), 32'h1);
      check("tbl_mix_out", 32'(bus.mix_out), 32'(ft[f].mix));
      wait_neg(te + 12);
      check("mix_valid_pulse", 32'(bus.mix_valid), 32'h0);
    end
    check("no_overrun", 32'(bus.overrun), 32'h0);

    // Mid-frame reset: abort after voice 1 has been captured.
    wait_neg(3000);
    sb_en     = 1'b0;
    tick_edge = 3000;
    rom_mode  = 1;
    wait_neg(3004);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_rom_addr", 32'(bus.rom_addr), 32'h0);
    check("abort_mix_out", 32'(bus.mix_out), 32'h0);
    model_reset();
    tick_edge = -100;
    rst = 1'b0;
    sb_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mix_valid === 1'b1) pulses++;
    end
    check("abort_no_mix", 32'(pulses), 32'h0);
    open_gates();
    wait_neg(500);
    tick_edge = 500;
    rom_mode  = 0;
    model_frame(0);
    wait_neg(511);
    check("post_abort_mix", 32'(bus.mix_out), 32'h123456);
    wait_neg(520);
    check("iq_empty", 32'(iq.size()), 32'h0);
    check("mq_empty", 32'(mq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
